// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_WAIT_CYCLES  = 2;
  localparam int DEF_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory macro.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Requesters plus memory macro side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_cs, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant choice: data first, fetch forced once the starvation counter is full.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  logic   starve_full_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid_o = if_req_i | dm_req_i;
    grant_owner_o = OWN_IF;
    if (dm_req_i && !(if_req_i && starve_full_i)) grant_owner_o = OWN_DM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the unified memory port (IF vs DM).
// Optional ARB_STATS_EN adds a saturating conflict counter output.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 64,
  parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy_o
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        conflict_count_o
`endif
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e        state_q, state_d;
  owner_e        owner_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [WW-1:0] wait_q;
  logic [SW-1:0] starve_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic   grant_valid;
  owner_e grant_owner;
  logic   in_access;
  logic   last_wait;

  mem_arb_pick u_pick (
    .if_req_i      (bus.if_req),
    .dm_req_i      (bus.dm_req),
    .starve_full_i (starve_q == SW'(STARVE_LIMIT)),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  assign in_access = (state_q == ACCESS);
  assign last_wait = (wait_q == '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (last_wait)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches, wait counter, starvation guard and read-data holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_owner;
            wait_q  <= WW'(WAIT_CYCLES - 1);
            if (grant_owner == OWN_DM) begin
              addr_q  <= bus.dm_addr;
              we_q    <= bus.dm_we;
              wdata_q <= bus.dm_wdata;
              if (!bus.if_req)                          starve_q <= '0;
              else if (starve_q != SW'(STARVE_LIMIT))   starve_q <= starve_q + SW'(1);
            end else begin
              addr_q   <= bus.if_addr;
              we_q     <= 1'b0;
              wdata_q  <= '0;
              starve_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (!last_wait) begin
            wait_q <= wait_q - WW'(1);
          end else if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_q <= bus.mem_rdata;
            else                   dm_rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory outputs are held at zero outside ACCESS so the macro sees a clean idle bus.
  assign bus.mem_cs    = in_access;
  assign bus.mem_we    = in_access & we_q;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  assign bus.if_ack   = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.dm_ack   = (state_q == DONE) && (owner_q == OWN_DM);
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign busy_o       = (state_q != IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_q <= '0;
    end else if ((state_q == IDLE) && bus.if_req && bus.dm_req && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count_o = conflict_q;
`endif

endmodule
